// File: rtl/axis_frame_len_limit_if.sv
// axis_if: AXI4-Stream bundle shared by the limiter's input and output sides
// Ports: tdata/tvalid/tlast/tuser flow from master to slave, tready flows back.
interface axis_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_frame_len_limit.sv
// axis_frame_len_limit: AXI4-Stream frame length limiter with truncation and a 2-entry registered output buffer
// Ports: clk, rst (async active-high); s_axis input stream (slave); m_axis output stream (master);
//   max_len beat limit sampled on each first beat (0 = no limit);
//   status_frame_len / status_frame_valid report beats forwarded per completed frame;
//   status_truncated pulses when a frame is cut short.
// Build option: AXIS_FRAME_LIMIT_MARK_BAD_EN forces tuser[0]=1 on the truncated last beat.
module axis_frame_len_limit #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_if.slave                s_axis,
    axis_if.master               m_axis,
    input  logic [LEN_WIDTH-1:0] max_len,
    output logic [LEN_WIDTH-1:0] status_frame_len,
    output logic                 status_frame_valid,
    output logic                 status_truncated
);
    localparam int W = DATA_WIDTH + USER_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;
    state_t state, state_n;
    logic [LEN_WIDTH-1:0] beat_cnt, limit_reg, cnt_after, lim;
    logic [USER_WIDTH-1:0] in_user;
    logic [W-1:0] e0, e1, e0_n, e1_n, in_word;
    logic v0, v1, v0_p, v1_p, v0_n, v1_n;
    logic ready, acc, fwd, trunc, done, pop;
    assign s_axis.tready = ready;
    assign m_axis.tvalid = v0;
    assign m_axis.tdata  = e0[W-1 -: DATA_WIDTH];
    assign m_axis.tuser  = e0[USER_WIDTH:1];
    assign m_axis.tlast  = e0[0];
    always_comb begin
        // a first beat counts as 1 and compares against the live max_len it is about to latch
        cnt_after = state == IDLE ? LEN_WIDTH'(1) : (&beat_cnt ? beat_cnt : beat_cnt + LEN_WIDTH'(1));
        lim       = state == IDLE ? max_len : limit_reg;
        acc       = s_axis.tvalid && ready;
        fwd       = acc && state != DROP;
        trunc     = fwd && !s_axis.tlast && lim != '0 && cnt_after == lim;
        done      = fwd && (s_axis.tlast || trunc);
        state_n   = state == DROP ? (acc && s_axis.tlast ? IDLE : DROP)
                  : !fwd ? state : s_axis.tlast ? IDLE : trunc ? DROP : PASS;
`ifdef AXIS_FRAME_LIMIT_MARK_BAD_EN
        in_user   = trunc ? s_axis.tuser | USER_WIDTH'(1) : s_axis.tuser;
`else
        in_user   = s_axis.tuser;
`endif
        in_word   = {s_axis.tdata, in_user, s_axis.tlast | trunc};
        // pop shifts entry 1 forward, then a forwarded beat lands in the first free slot
        pop       = v0 && m_axis.tready;
        v0_p      = pop ? v1 : v0;
        v1_p      = pop ? 1'b0 : v1;
        e0_n      = fwd && !v0_p ? in_word : pop ? e1 : e0;
        e1_n      = fwd && v0_p ? in_word : e1;
        v0_n      = v0_p || fwd;
        v1_n      = v1_p || (fwd && v0_p);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt           <= '0;
            limit_reg          <= '0;
            e0                 <= '0;
            e1                 <= '0;
            v0                 <= 1'b0;
            v1                 <= 1'b0;
            ready              <= 1'b0;
            status_frame_len   <= '0;
            status_frame_valid <= 1'b0;
            status_truncated   <= 1'b0;
        end else begin
            beat_cnt           <= fwd ? cnt_after : beat_cnt;
            limit_reg          <= fwd && state == IDLE ? max_len : limit_reg;
            e0                 <= e0_n;
            e1                 <= e1_n;
            v0                 <= v0_n;
            v1                 <= v1_n;
            // dropping never touches the buffer, so the input stays open while discarding
            ready              <= state_n == DROP || !v1_n;
            status_frame_len   <= done ? cnt_after : status_frame_len;
            status_frame_valid <= done;
            status_truncated   <= trunc;
        end
    end
endmodule
